// File: rtl/pattern_detector_pkg.sv
// Shared definitions for the serial pattern detector: FSM state encodings
// and default widths used by the top and its counter.
package pattern_detector_pkg;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_HUNT  = 2'd1;
    localparam logic [1:0] ST_MATCH = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over
// the increment.
module sat_counter
    import pattern_detector_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_r;

    // Count register: clear beats increment, increment stops at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/pattern_detector_param.sv
// Serial pattern detector: shifts qualified bits into a history register and
// flags (Moore, one cycle late) when the history equals a loadable pattern.
module pattern_detector_param
    import pattern_detector_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b0110,
    parameter int               CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i,
    input  logic             i_vld,
    input  logic             pat_ld,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             ovl,
    input  logic             cnt_clr,
    output logic             o,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [1:0]        state_r;
    logic [1:0]        state_nx_s;
    logic [FILL_W-1:0] fill_r;
    logic [FILL_W-1:0] fill_nx_s;
    logic [FILL_W-1:0] fill_inc_s;
    logic [PAT_W-1:0]  hist_r;
    logic [PAT_W-1:0]  hist_nx_s;
    logic [PAT_W-1:0]  hist_shift_s;
    logic [PAT_W-1:0]  pat_r;
    logic [PAT_W-1:0]  pat_nx_s;
    logic              o_r;
    logic              accept_s;
    logic              match_s;

    // A pattern load swallows any bit presented on the same edge.
    assign accept_s     = i_vld & ~pat_ld;
    assign hist_shift_s = {hist_r[PAT_W-2:0], i};
    assign fill_inc_s   = (fill_r == FILL_FULL) ? FILL_FULL : fill_r + FILL_W'(1);
    assign match_s      = accept_s && (hist_shift_s == pat_r) && (fill_inc_s == FILL_FULL);

    // Next-state logic; idle cycles hold everything, including MATCH.
    always_comb begin
        state_nx_s = state_r;
        fill_nx_s  = fill_r;
        hist_nx_s  = hist_r;
        pat_nx_s   = pat_r;
        if (pat_ld) begin
            pat_nx_s   = pat_in;
            hist_nx_s  = {PAT_W{1'b0}};
            fill_nx_s  = {FILL_W{1'b0}};
            state_nx_s = ST_FILL;
        end else if (accept_s) begin
            hist_nx_s = hist_shift_s;
            if (match_s) begin
                state_nx_s = ST_MATCH;
                // Non-overlapping mode demands a full set of fresh bits.
                fill_nx_s  = ovl ? fill_inc_s : {FILL_W{1'b0}};
            end else begin
                state_nx_s = (fill_inc_s == FILL_FULL) ? ST_HUNT : ST_FILL;
                fill_nx_s  = fill_inc_s;
            end
        end else begin
            state_nx_s = state_r;
        end
    end

    // Detector state registers; o is registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_FILL;
            fill_r  <= {FILL_W{1'b0}};
            hist_r  <= {PAT_W{1'b0}};
            pat_r   <= PAT_RST;
            o_r     <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            fill_r  <= fill_nx_s;
            hist_r  <= hist_nx_s;
            pat_r   <= pat_nx_s;
            o_r     <= (state_nx_s == ST_MATCH);
        end
    end

    assign o = o_r;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (match_s),
        .cnt (match_cnt)
    );

endmodule

// File: tb/tb_pattern_detector_param.sv
// Directed bench for pattern_detector_param; a second instance with a 2-bit
// counter shares all inputs to exercise saturation.
module tb_pattern_detector_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i = 1'b0;
    logic       i_vld = 1'b0;
    logic       pat_ld = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic       ovl = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       o;
    logic [7:0] match_cnt;
    logic       o2;
    logic [1:0] match_cnt2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pattern_detector_param dut (
        .clk(clk), .rst(rst), .i(i), .i_vld(i_vld), .pat_ld(pat_ld),
        .pat_in(pat_in), .ovl(ovl), .cnt_clr(cnt_clr),
        .o(o), .match_cnt(match_cnt)
    );

    pattern_detector_param #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .i(i), .i_vld(i_vld), .pat_ld(pat_ld),
        .pat_in(pat_in), .ovl(ovl), .cnt_clr(cnt_clr),
        .o(o2), .match_cnt(match_cnt2)
    );

    task automatic send_bit(input logic b);
        @(negedge clk);
        i = b;
        i_vld = 1'b1;
        @(posedge clk);
        #1;
        i_vld = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        i_vld = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (o !== 1'b0) begin
            bad++;
            $display("FAIL reset_o: got %b want 0", o);
        end
        total++;
        if (match_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_cnt: got %0d want 0", match_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_overlap();
        logic [6:0] bits = 7'b0110110;
        logic [6:0] exp  = 7'b0001001;
        do_reset();
        ovl = 1'b1;
        for (int k = 0; k < 7; k++) begin
            send_bit(bits[6-k]);
            total++;
            if (o !== exp[6-k]) begin
                bad++;
                $display("FAIL ovl_o bit%0d: got %b want %b", k + 1, o, exp[6-k]);
            end
        end
        total++;
        if (match_cnt !== 8'd2) begin
            bad++;
            $display("FAIL ovl_cnt: got %0d want 2", match_cnt);
        end
    endtask

    task automatic test_non_overlap();
        logic [6:0] bits = 7'b0110110;
        logic [6:0] exp  = 7'b0001000;
        do_reset();
        ovl = 1'b0;
        for (int k = 0; k < 7; k++) begin
            send_bit(bits[6-k]);
            total++;
            if (o !== exp[6-k]) begin
                bad++;
                $display("FAIL novl_o bit%0d: got %b want %b", k + 1, o, exp[6-k]);
            end
        end
        total++;
        if (match_cnt !== 8'd1) begin
            bad++;
            $display("FAIL novl_cnt: got %0d want 1", match_cnt);
        end
    endtask

    // The load edge carries a 1 that must be discarded.
    task automatic test_pat_load();
        logic [5:0] exp = 6'b000111;
        do_reset();
        ovl = 1'b1;
        @(negedge clk);
        pat_ld = 1'b1;
        pat_in = 4'b1111;
        i = 1'b1;
        i_vld = 1'b1;
        @(posedge clk);
        #1;
        pat_ld = 1'b0;
        i_vld = 1'b0;
        total++;
        if (o !== 1'b0) begin
            bad++;
            $display("FAIL load_o: got %b want 0", o);
        end
        for (int k = 0; k < 6; k++) begin
            send_bit(1'b1);
            total++;
            if (o !== exp[5-k]) begin
                bad++;
                $display("FAIL load_o bit%0d: got %b want %b", k + 1, o, exp[5-k]);
            end
        end
        total++;
        if (match_cnt !== 8'd3) begin
            bad++;
            $display("FAIL load_cnt: got %0d want 3", match_cnt);
        end
    endtask

    task automatic test_saturate();
        logic [3:0] pat = 4'b0110;
        do_reset();
        ovl = 1'b0;
        for (int m = 0; m < 5; m++) begin
            for (int k = 0; k < 4; k++) begin
                send_bit(pat[3-k]);
            end
        end
        total++;
        if (match_cnt !== 8'd5) begin
            bad++;
            $display("FAIL sat_cnt8: got %0d want 5", match_cnt);
        end
        total++;
        if (match_cnt2 !== 2'd3) begin
            bad++;
            $display("FAIL sat_cnt2: got %0d want 3", match_cnt2);
        end
        @(negedge clk);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        total++;
        if (match_cnt2 !== 2'd0) begin
            bad++;
            $display("FAIL clr_cnt2: got %0d want 0", match_cnt2);
        end
        // Clear coinciding with a match: match flagged, count stays 0.
        for (int k = 0; k < 3; k++) begin
            send_bit(pat[3-k]);
        end
        @(negedge clk);
        i = 1'b0;
        i_vld = 1'b1;
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        i_vld = 1'b0;
        cnt_clr = 1'b0;
        total++;
        if (o !== 1'b1) begin
            bad++;
            $display("FAIL clrmatch_o: got %b want 1", o);
        end
        total++;
        if (match_cnt !== 8'd0) begin
            bad++;
            $display("FAIL clrmatch_cnt: got %0d want 0", match_cnt);
        end
    endtask

    task automatic test_rst_midstream();
        logic [3:0] bits = 4'b0110;
        do_reset();
        ovl = 1'b1;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        do_reset();
        send_bit(1'b0);
        total++;
        if (o !== 1'b0) begin
            bad++;
            $display("FAIL midrst_o: got %b want 0", o);
        end
        for (int k = 0; k < 4; k++) begin
            send_bit(bits[3-k]);
            total++;
            if (o !== (k == 3)) begin
                bad++;
                $display("FAIL midrst_o bit%0d: got %b want %b", k + 1, o, (k == 3));
            end
        end
        total++;
        if (match_cnt !== 8'd1) begin
            bad++;
            $display("FAIL midrst_cnt: got %0d want 1", match_cnt);
        end
    endtask

    task automatic test_idle_gaps();
        do_reset();
        ovl = 1'b1;
        send_bit(1'b0);
        idle_cycle();
        idle_cycle();
        send_bit(1'b1);
        idle_cycle();
        send_bit(1'b1);
        for (int k = 0; k < 3; k++) begin
            idle_cycle();
            total++;
            if (o !== 1'b0) begin
                bad++;
                $display("FAIL gap_pre_o idle%0d: got %b want 0", k, o);
            end
        end
        send_bit(1'b0);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (o !== 1'b1) begin
                bad++;
                $display("FAIL gap_hold_o idle%0d: got %b want 1", k, o);
            end
            idle_cycle();
        end
        total++;
        if (match_cnt !== 8'd1) begin
            bad++;
            $display("FAIL gap_cnt: got %0d want 1", match_cnt);
        end
        // Reset must drop o without waiting for a clock edge.
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (o !== 1'b0) begin
            bad++;
            $display("FAIL async_rst_o: got %b want 0", o);
        end
        total++;
        if (match_cnt !== 8'd0) begin
            bad++;
            $display("FAIL async_rst_cnt: got %0d want 0", match_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_pat_load();
        test_saturate();
        test_rst_midstream();
        test_idle_gaps();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
